// File: rtl/elevator_call_scheduler.sv
// SCAN collective-control scheduler: latches floor calls, picks direction,
// drives the motor enables and a timed door-open phase.
module elevator_call_scheduler #(
  parameter int FLOORS      = 3,
  parameter int DOOR_CYCLES = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLOORS-1:0] call,
  input  logic [FLOORS-1:0] at_floor,
  output logic              mup,
  output logic              mdw,
  output logic              door_open,
  output logic              dir_up,
  output logic [3:0]        floor_num,
  output logic [FLOORS-1:0] pending,
  output logic              moving
);

  localparam int TW = $clog2(DOOR_CYCLES + 1);
  localparam logic [TW-1:0] TLOAD = TW'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    UP,
    DOWN,
    DOOR
  } state_t;

  state_t            state_q;
  logic [3:0]        cur_q;
  logic [3:0]        fnum_q;
  logic [TW-1:0]     timer_q;
  logic [FLOORS-1:0] pend_q;
  logic              mup_q;
  logic              mdw_q;
  logic              door_q;
  logic              dir_q;
  logic              mov_q;

  logic [3:0]        cnt;
  logic [3:0]        k;
  logic              hit;
  logic [3:0]        cur_d;
  logic [FLOORS-1:0] cur_oh;
  logic [FLOORS-1:0] old_oh;
  logic [FLOORS-1:0] door_mask;
  logic [FLOORS-1:0] pend_nx;
  logic              above;
  logic              below;
  logic              here;
  logic              call_cur;

  always_comb begin
    cnt = '0;
    k   = '0;
    for (int i = 0; i < FLOORS; i++) begin
      if (at_floor[i]) begin
        cnt = cnt + 4'd1;
        k   = 4'(i);
      end
    end
  end

  assign hit   = (cnt == 4'd1);
  assign cur_d = hit ? k : cur_q;

  // A re-press at the open door only extends the door, it is not a new call.
  always_comb begin
    cur_oh = '0;
    old_oh = '0;
    above  = 1'b0;
    below  = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      cur_oh[i] = (4'(i) == cur_d);
      old_oh[i] = (4'(i) == cur_q);
    end
    door_mask = (state_q == DOOR) ? old_oh : {FLOORS{1'b0}};
    pend_nx   = pend_q | (call & ~door_mask);
    for (int i = 0; i < FLOORS; i++) begin
      if (4'(i) > cur_d) above = above | pend_nx[i];
      if (4'(i) < cur_d) below = below | pend_nx[i];
    end
  end

  assign here     = |(pend_nx & cur_oh);
  assign call_cur = |(call & old_oh);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cur_q   <= '0;
      fnum_q  <= 4'd1;
      timer_q <= '0;
      pend_q  <= '0;
      mup_q   <= 1'b0;
      mdw_q   <= 1'b0;
      door_q  <= 1'b0;
      dir_q   <= 1'b1;
      mov_q   <= 1'b0;
    end else begin
      cur_q  <= cur_d;
      fnum_q <= cur_d + 4'd1;
      pend_q <= pend_nx;
      unique case (state_q)
        IDLE: begin
          if (here) begin
            state_q <= DOOR;
            door_q  <= 1'b1;
            timer_q <= TLOAD;
            pend_q  <= pend_nx & ~cur_oh;
          end else if (above && (dir_q || !below)) begin
            state_q <= UP;
            dir_q   <= 1'b1;
            mup_q   <= 1'b1;
            mov_q   <= 1'b1;
          end else if (below) begin
            state_q <= DOWN;
            dir_q   <= 1'b0;
            mdw_q   <= 1'b1;
            mov_q   <= 1'b1;
          end
        end
        UP: begin
          if (hit) begin
            if (k < cur_q) begin
              state_q <= IDLE;
              mup_q   <= 1'b0;
              mov_q   <= 1'b0;
            end else if (here) begin
              state_q <= DOOR;
              mup_q   <= 1'b0;
              mov_q   <= 1'b0;
              door_q  <= 1'b1;
              timer_q <= TLOAD;
              pend_q  <= pend_nx & ~cur_oh;
            end else if (at_floor[FLOORS-1] || !above) begin
              state_q <= IDLE;
              mup_q   <= 1'b0;
              mov_q   <= 1'b0;
            end
          end
        end
        DOWN: begin
          if (hit) begin
            if (k > cur_q) begin
              state_q <= IDLE;
              mdw_q   <= 1'b0;
              mov_q   <= 1'b0;
            end else if (here) begin
              state_q <= DOOR;
              mdw_q   <= 1'b0;
              mov_q   <= 1'b0;
              door_q  <= 1'b1;
              timer_q <= TLOAD;
              pend_q  <= pend_nx & ~cur_oh;
            end else if (at_floor[0] || !below) begin
              state_q <= IDLE;
              mdw_q   <= 1'b0;
              mov_q   <= 1'b0;
            end
          end
        end
        DOOR: begin
          if (call_cur) begin
            timer_q <= TLOAD;
          end else if (timer_q == '0) begin
            state_q <= IDLE;
            door_q  <= 1'b0;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
      endcase
    end
  end

  assign mup       = mup_q;
  assign mdw       = mdw_q;
  assign door_open = door_q;
  assign dir_up    = dir_q;
  assign floor_num = fnum_q;
  assign pending   = pend_q;
  assign moving    = mov_q;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Bench for elevator_call_scheduler: directed trips checked against a
// floor-level behavioural model every cycle plus literal expectations.
module tb_elevator_call_scheduler;

  localparam int F  = 3;
  localparam int DC = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [F-1:0] call = '0;
  logic [F-1:0] at_floor = 3'b001;
  logic         mup;
  logic         mdw;
  logic         door_open;
  logic         dir_up;
  logic [3:0]   floor_num;
  logic [F-1:0] pending;
  logic         moving;

  int checks = 0;
  int errors = 0;
  bit armed = 1'b0;

  elevator_call_scheduler #(
    .FLOORS(F),
    .DOOR_CYCLES(DC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .call(call),
    .at_floor(at_floor),
    .mup(mup),
    .mdw(mdw),
    .door_open(door_open),
    .dir_up(dir_up),
    .floor_num(floor_num),
    .pending(pending),
    .moving(moving)
  );

  always #5 clk = ~clk;

  // Model: motion is +1/-1/0, door_left counts remaining open cycles.
  logic [F-1:0] m_pend = '0;
  int m_cur = 0;
  int m_motion = 0;
  int m_pref = 1;
  int m_door = 0;

  always @(posedge clk) begin : model
    int ones, idx, nc, dl, mo, pf;
    logic [F-1:0] req, callm;
    bit up_any, dn_any;
    if (!reset) begin
      m_pend   <= '0;
      m_cur    <= 0;
      m_motion <= 0;
      m_pref   <= 1;
      m_door   <= 0;
    end else begin
      ones = 0;
      idx  = 0;
      for (int i = 0; i < F; i++)
        if (at_floor[i]) begin
          ones++;
          idx = i;
        end
      nc = (ones == 1) ? idx : m_cur;
      callm = call;
      if (m_door > 0) callm[m_cur] = 1'b0;
      req = m_pend | callm;
      up_any = 0;
      dn_any = 0;
      for (int i = 0; i < F; i++) begin
        if (req[i] && i > nc) up_any = 1;
        if (req[i] && i < nc) dn_any = 1;
      end
      dl = m_door;
      mo = m_motion;
      pf = m_pref;
      if (dl > 0) begin
        dl = call[m_cur] ? DC : dl - 1;
      end else if (mo == 0) begin
        if (req[nc]) begin
          dl = DC;
          req[nc] = 1'b0;
        end else if (up_any && (pf == 1 || !dn_any)) begin
          mo = 1;
          pf = 1;
        end else if (dn_any) begin
          mo = -1;
          pf = 0;
        end
      end else if (ones == 1) begin
        if ((mo > 0 && idx < m_cur) || (mo < 0 && idx > m_cur)) mo = 0;
        else if (req[idx]) begin
          mo = 0;
          dl = DC;
          req[idx] = 1'b0;
        end
        else if (mo > 0 && !up_any) mo = 0;
        else if (mo < 0 && !dn_any) mo = 0;
      end
      m_pend   <= req;
      m_cur    <= nc;
      m_motion <= mo;
      m_pref   <= pf;
      m_door   <= dl;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      chk("mdl_mup", int'(mup), int'(m_motion > 0));
      chk("mdl_mdw", int'(mdw), int'(m_motion < 0));
      chk("mdl_door", int'(door_open), int'(m_door > 0));
      chk("mdl_dir", int'(dir_up), m_pref);
      chk("mdl_floor", int'(floor_num), m_cur + 1);
      chk("mdl_pend", int'(pending), int'(m_pend));
      chk("mdl_moving", int'(moving), int'(m_motion != 0));
      chk("inv_updown", int'(mup & mdw), 0);
      chk("inv_doormove", int'(door_open & moving), 0);
    end
  end

  task automatic door_len(input string name, input int exp);
    int n;
    n = 0;
    while (door_open === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk(name, n, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    step(2);
    armed = 1'b1;
    chk("rst_floor", int'(floor_num), 1);
    chk("rst_mup", int'(mup), 0);
    chk("rst_pend", int'(pending), 0);
    chk("rst_dir", int'(dir_up), 1);
    chk("rst_door", int'(door_open), 0);
    reset = 1'b1;

    // Trip 1: floor 1 -> 3, passing floor 2.
    call = 3'b100;
    step(1);
    chk("t1_mup", int'(mup), 1);
    call = 3'b000;
    step(1);
    at_floor = 3'b000;
    step(2);
    at_floor = 3'b010;
    step(1);
    chk("t1_pass_floor", int'(floor_num), 2);
    chk("t1_pass_mup", int'(mup), 1);
    at_floor = 3'b000;
    step(2);
    at_floor = 3'b100;
    step(1);
    chk("t1_stop_mup", int'(mup), 0);
    chk("t1_door", int'(door_open), 1);
    chk("t1_floor", int'(floor_num), 3);
    door_len("t1_door_len", 8);
    chk("t1_pend", int'(pending), 0);

    // Trip 2: from floor 3 call floors 1 and 2.
    call = 3'b011;
    step(1);
    chk("t2_mdw", int'(mdw), 1);
    chk("t2_dir", int'(dir_up), 0);
    call = 3'b000;
    at_floor = 3'b000;
    step(2);
    at_floor = 3'b010;
    step(1);
    chk("t2_door2", int'(door_open), 1);
    chk("t2_pend", int'(pending), 1);
    door_len("t2_door_len", 8);
    step(1);
    chk("t2_resume", int'(mdw), 1);
    at_floor = 3'b000;
    step(2);
    at_floor = 3'b001;
    step(1);
    chk("t2_floor1", int'(floor_num), 1);
    chk("t2_door1", int'(door_open), 1);
    door_len("t2_door1_len", 8);

    // Trip 3: go to floor 2, then calls on 1 and 3 together.
    call = 3'b010;
    step(1);
    call = 3'b000;
    at_floor = 3'b000;
    step(1);
    at_floor = 3'b010;
    step(1);
    door_len("t3_door_a", 8);
    call = 3'b101;
    step(1);
    chk("t3_scan_up", int'(mup), 1);
    call = 3'b000;
    at_floor = 3'b000;
    step(1);
    at_floor = 3'b100;
    step(1);
    chk("t3_floor3", int'(floor_num), 3);
    chk("t3_pend", int'(pending), 1);
    door_len("t3_door_b", 8);
    step(1);
    chk("t3_down", int'(mdw), 1);
    at_floor = 3'b000;
    step(1);
    at_floor = 3'b010;
    step(1);
    chk("t3_pass2", int'(mdw), 1);
    at_floor = 3'b000;
    step(1);
    at_floor = 3'b001;
    step(1);
    chk("t3_floor1", int'(floor_num), 1);
    door_len("t3_door_c", 8);

    // Trip 4: door at floor 2 with a held re-press.
    call = 3'b010;
    step(1);
    call = 3'b000;
    at_floor = 3'b000;
    step(1);
    at_floor = 3'b010;
    step(1);
    chk("t4_door", int'(door_open), 1);
    step(5);
    call = 3'b010;
    step(5);
    chk("t4_pend_held", int'(pending), 0);
    call = 3'b000;
    door_len("t4_after_release", 8);
    chk("t4_pend", int'(pending), 0);

    // Trip 5: reset mid-travel.
    call = 3'b100;
    step(1);
    call = 3'b000;
    at_floor = 3'b000;
    step(1);
    chk("t5_moving", int'(mup), 1);
    reset = 1'b0;
    step(1);
    chk("t5_mup", int'(mup), 0);
    chk("t5_pend", int'(pending), 0);
    chk("t5_floor", int'(floor_num), 1);
    reset = 1'b1;

    // Trip 6: sensor fault while going up.
    at_floor = 3'b010;
    step(1);
    call = 3'b100;
    step(1);
    chk("t6_mup", int'(mup), 1);
    call = 3'b000;
    at_floor = 3'b000;
    step(1);
    at_floor = 3'b001;
    step(1);
    chk("t6_fault_mup", int'(mup), 0);
    chk("t6_fault_pend", int'(pending), 4);
    chk("t6_fault_door", int'(door_open), 0);
    at_floor = 3'b000;
    step(2);
    at_floor = 3'b100;
    step(1);
    door_len("t6_door", 8);
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/elevator_call_scheduler.md
Name: elevator_call_scheduler

Overview:
Collective-control scheduler for the elevator car. It latches hall/car call buttons for every floor and picks the travel direction with a SCAN policy: keep going while calls remain ahead. It drives the up/down motor enables and a timed door-open phase. It replaces the fixed-path floor FSM. Its outputs feed the existing motor drivers and the BCD floor display/blink decoder.

Parameters:
FLOORS, 3, number of floors (2..9); floor index 0 = ground.
DOOR_CYCLES, 8, clock cycles door_open stays high per stop (>=1).

Ports:
clk  in  1  system clock, all logic on posedge.
reset  in  1  synchronous, active-low reset.
call  in  FLOORS  call buttons, bit i = floor i; level, may be held.
at_floor  in  FLOORS  floor sensors; one-hot when the car is level with a floor, all-zero between floors.
mup  out  1  motor up enable.
mdw  out  1  motor down enable.
door_open  out  1  door open command.
dir_up  out  1  current travel preference (1 = up).
floor_num  out  4  current floor, 1-based binary (1..FLOORS), for the BCD display.
pending  out  FLOORS  latched, unserved calls.
moving  out  1  mup|mdw, drives display blink enable.

Behaviour:
- All outputs are registered (Moore). Edge with reset==0 sets: state=IDLE, pending=0, cur=0 (floor_num=1), mup=mdw=door_open=0, dir_up=1, timer=0. Reset works from any state, including mid-travel and door-open.
- cur update: if at_floor has exactly one bit k set, cur<=k. Zero or multiple bits set: cur holds.
- pend_nx = pending | call, combinational. pending<=pend_nx, except the served floor's bit is cleared on the edge that enters DOOR. Clear wins over a simultaneous call on that floor.
- above = |pend_nx[FLOORS-1:cur+1], below = |pend_nx[cur-1:0], using the cur value as updated this edge.
- States: IDLE, UP, DOWN, DOOR.
- IDLE, decisions in priority order:
  - pend_nx[cur]: go to DOOR.
  - above and (dir_up or !below): go to UP, dir_up=1, mup=1.
  - below: go to DOWN, dir_up=0, mdw=1.
  - otherwise stay.
  - Latency: a call sampled at edge t gives mup/mdw/door_open high after edge t.
- UP: mup=1. On an edge where at_floor==one-hot k:
  - pend_nx[k]: go to DOOR, mup=0.
  - else if k==FLOORS-1 or no pending above k: go to IDLE, mup=0.
  - else keep moving.
  - At the top floor mup is always deasserted.
- DOWN: mirror of UP, using mdw, "below", and floor 0.
- Sensor fault while moving (at_floor one-hot k with k<cur in UP, or k>cur in DOWN): go to IDLE, motors off, pending kept.
- DOOR: door_open=1, motors off, timer loads DOOR_CYCLES-1 on entry and counts down. call[cur] during DOOR reloads the timer and does not set pending. Timer==0 with no reload: go to IDLE, door_open=0. Door is high exactly DOOR_CYCLES cycles when there are no re-presses.
- Invariants:
  - mup&mdw is never 1.
  - door_open is never 1 while moving is 1.
  - Motors change only on state transitions.
- Timer width is clog2(DOOR_CYCLES+1). pending bits outside 0..FLOORS-1 do not exist.

Test Plan:
1. Reset low 2 cycles at floor 1, then call=3'b100 one cycle. Expect mup=1 next cycle, floor_num updates at 2 with no stop. At_floor=3'b100 gives mup=0, door_open=1 for 8 cycles, then IDLE, pending=0.
2. Car at floor 3, IDLE, dir_up=1; call floors 1 and 2 together. Expect mdw=1, dir_up=0. Stop at floor 2: door 8 cycles, pending=3'b001. Then resume mdw and stop at floor 1.
3. Car at floor 2, dir_up=1; call floors 1 and 3 on the same cycle. Expect UP first (SCAN), serve floor 3, then DOWN to floor 1.
4. DOOR at floor 2, call[1] held 5 cycles starting at timer=2. Expect door_open to stay high until 8 cycles after call release. pending[1] stays 0.
5. Reset driven low while mup=1 between floors. Expect mup=0, pending=0, floor_num=1, state IDLE on that edge.
6. Car moving UP from floor 2, at_floor=3'b001 (fault). Expect mup=0, IDLE, pending unchanged. Check mup&mdw==0 and door_open&moving==0 every cycle across all tests.
